// File: rtl/core_ctrl_pkg.sv
// Shared control-unit definitions for the 5-stage core.
//  MODE_ARITH / OP_SORT : decode constants identifying a SORT in ID
//  seq_state_t          : sequencer state (IDLE, SORT2)
package core_ctrl_pkg;

  localparam logic [1:0] MODE_ARITH = 2'b00;
  localparam logic [3:0] OP_SORT    = 4'b0011;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SORT2 = 1'b1
  } seq_state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// SRAM wait-state timer. Counts consecutive stalled MEM cycles and raises a sticky
// timeout flag, after which the stall is suppressed so the pipeline can drain.
//  clk, rst    : clock, asynchronous active-high reset
//  mem_access  : MEM stage performs a load/store
//  sram_ready  : SRAM completes the access this cycle
//  mem_stall   : pipeline must wait on the SRAM this cycle
//  mem_error   : sticky timeout flag, cleared only by rst
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_access,
  input  logic sram_ready,
  output logic mem_stall,
  output logic mem_error
);

  localparam logic [TO_W-1:0] LastWait = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] wait_cnt_q;
  logic            mem_error_q;

  assign mem_stall = mem_access & ~sram_ready & ~mem_error_q;
  assign mem_error = mem_error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
    end else if (mem_stall) begin
      // Final permitted stall cycle: flag the error, which drops mem_stall next cycle.
      if (wait_cnt_q == LastWait) begin
        mem_error_q <= 1'b1;
      end else begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

endmodule

// File: rtl/multicycle_seq_ctrl.sv
// Pipeline sequencer beside the ID-stage control unit. Issues SORT to EXE as two halves
// (sort_cycle_count 0 then 1) and arbitrates freeze/bubble/flush for SRAM waits, taken
// branches and RAW hazards. Priority: mem_stall > branch_taken > hazard > SORT.
//  Inputs : clk, rst (async, active high), id_valid, id_mode, id_op_code, hazard,
//           branch_taken, mem_access, sram_ready
//  Outputs: sort_cycle_count, freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id,
//           freeze_all, mem_error
//  Optional macro SEQ_STATS_EN adds saturating counters stall_cycles and sort_count.
module multicycle_seq_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
`ifdef SEQ_STATS_EN
  ,
  parameter int unsigned STAT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [1:0]       id_mode,
  input  logic [3:0]       id_op_code,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             sram_ready,
  output logic             sort_cycle_count,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             bubble_id_exe,
  output logic             flush_if_id,
  output logic             freeze_all,
  output logic             mem_error
`ifdef SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] sort_count
`endif
);

  seq_state_t state_q, state_d;
  logic       sort_id;
  logic       mem_stall;

  assign sort_id = id_valid & (id_mode == MODE_ARITH) & (id_op_code == OP_SORT);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_mem_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .mem_access(mem_access),
    .sram_ready(sram_ready),
    .mem_stall (mem_stall),
    .mem_error (mem_error)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered only: no input-to-output path.
  assign sort_cycle_count = (state_q == SORT2);

  always_comb begin
    state_d       = state_q;
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    bubble_id_exe = 1'b0;
    flush_if_id   = 1'b0;
    freeze_all    = 1'b0;
    if (rst) begin
      // Outputs held quiet while reset is asserted.
    end else if (mem_stall) begin
      freeze_all   = 1'b1;
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
    end else if (branch_taken) begin
      flush_if_id   = 1'b1;
      bubble_id_exe = 1'b1;
      state_d       = IDLE;
    end else if (hazard) begin
      // State holds so a stalled second half re-issues as the second half.
      freeze_pc     = 1'b1;
      freeze_if_id  = 1'b1;
      bubble_id_exe = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sort_id) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
            state_d      = SORT2;
          end
        end
        SORT2: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef SEQ_STATS_EN
  logic sort_done;
  assign sort_done = (state_q == SORT2) & ~mem_stall & ~branch_taken & ~hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      sort_count   <= '0;
    end else begin
      if (freeze_pc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
      if (sort_done && (sort_count != '1)) begin
        sort_count <= sort_count + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_seq_ctrl.sv
// Scoreboard bench for multicycle_seq_ctrl: directed scenarios then randomized traffic,
// with expected outputs computed by a behavioural model of the sequencing rules.
module tb_multicycle_seq_ctrl;

  localparam int unsigned MT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [1:0] id_mode = 2'b00;
  logic [3:0] id_op_code = 4'b0000;
  logic       hazard = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_access = 1'b0;
  logic       sram_ready = 1'b0;
  logic       sort_cycle_count, freeze_pc, freeze_if_id, bubble_id_exe;
  logic       flush_if_id, freeze_all, mem_error;
`ifdef SEQ_STATS_EN
  logic [31:0] stall_cycles, sort_count;
`endif

  always #5 clk = ~clk;

  multicycle_seq_ctrl #(
    .MEM_TIMEOUT(MT),
    .TO_W       (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_mode         (id_mode),
    .id_op_code      (id_op_code),
    .hazard          (hazard),
    .branch_taken    (branch_taken),
    .mem_access      (mem_access),
    .sram_ready      (sram_ready),
    .sort_cycle_count(sort_cycle_count),
    .freeze_pc       (freeze_pc),
    .freeze_if_id    (freeze_if_id),
    .bubble_id_exe   (bubble_id_exe),
    .flush_if_id     (flush_if_id),
    .freeze_all      (freeze_all),
    .mem_error       (mem_error)
`ifdef SEQ_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .sort_count      (sort_count)
`endif
  );

  // Expected outputs packed {scc, freeze_pc, freeze_if_id, bubble, flush, freeze_all, mem_error}.
  typedef struct {
    logic [6:0]  o;
    int unsigned st;
    int unsigned sc;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: are we between the two halves of a SORT, how long has the SRAM stalled,
  // has it timed out, and the statistics tallies.
  bit          m_second = 0;
  bit          m_err = 0;
  int          m_wait = 0;
  int unsigned m_stalls = 0;
  int unsigned m_sorts = 0;

  task automatic step(input logic r, input logic v, input logic [1:0] m, input logic [3:0] op,
                      input logic hz, input logic br, input logic ma, input logic sr);
    exp_t e;
    bit sid, ms, fpc, fif, bub, fl, fall;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_mode = m; id_op_code = op;
    hazard = hz; branch_taken = br; mem_access = ma; sram_ready = sr;
    e.o = '0; e.st = m_stalls; e.sc = m_sorts; e.cyc = cyc;
    fpc = 0; fif = 0; bub = 0; fl = 0; fall = 0;
    if (r) begin
      e.st = 0; e.sc = 0;
      m_second = 0; m_err = 0; m_wait = 0; m_stalls = 0; m_sorts = 0;
    end else begin
      sid = v && (m == 2'b00) && (op == 4'b0011);
      ms  = ma && !sr && !m_err;
      e.o[6] = m_second;
      e.o[0] = m_err;
      if (ms) begin
        fall = 1; fpc = 1; fif = 1;
        if (m_wait == int'(MT) - 1) m_err = 1;
        else m_wait++;
      end else begin
        m_wait = 0;
        if (br) begin
          fl = 1; bub = 1; m_second = 0;
        end else if (hz) begin
          fpc = 1; fif = 1; bub = 1;
        end else if (m_second) begin
          m_second = 0;
          m_sorts++;
        end else if (sid) begin
          fpc = 1; fif = 1; m_second = 1;
        end
      end
      if (fpc) m_stalls++;
      e.o[5:1] = {fpc, fif, bub, fl, fall};
    end
    q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 4'h0, 0, 0, 0, 1);
  endtask

  task automatic sort_in(input logic hz, input logic br, input logic ma, input logic sr);
    step(0, 1, 2'b00, 4'b0011, hz, br, ma, sr);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [6:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {sort_cycle_count, freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id,
             freeze_all, mem_error};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL outputs cyc %0d got %b want %b (scc,fpc,fif,bub,flush,fall,merr)",
                 e.cyc, act, e.o);
      end
`ifdef SEQ_STATS_EN
      checks++;
      if (stall_cycles !== e.st || sort_count !== e.sc) begin
        errors++;
        $display("FAIL stats cyc %0d got stall=%0d sort=%0d want stall=%0d sort=%0d",
                 e.cyc, stall_cycles, sort_count, e.st, e.sc);
      end
`endif
    end
  end

  initial begin
    logic v, hz, br, ma, sr, r;
    logic [1:0] m;
    logic [3:0] op;
    // Reset state.
    step(1, 0, 2'b00, 4'h0, 0, 0, 0, 0);
    step(1, 1, 2'b00, 4'b0011, 0, 0, 0, 0);
    idle(2);
    // Plain SORT: freeze then second half then idle.
    sort_in(0, 0, 0, 1); sort_in(0, 0, 0, 1); idle(1);
    // id_valid=0 with SORT encoding never starts one.
    step(0, 0, 2'b00, 4'b0011, 0, 0, 0, 1); idle(1);
    // Back-to-back SORTs.
    repeat (4) sort_in(0, 0, 0, 1);
    idle(1);
    // Hazard held two cycles during SORT2.
    sort_in(0, 0, 0, 1); sort_in(1, 0, 0, 1); sort_in(1, 0, 0, 1); sort_in(0, 0, 0, 1); idle(1);
    // Branch during SORT2 aborts it.
    sort_in(0, 0, 0, 1); sort_in(0, 1, 0, 1); idle(2);
    // SRAM wait for 3 cycles during SORT2, with a branch masked by the stall.
    sort_in(0, 0, 0, 1); sort_in(0, 0, 1, 0); sort_in(0, 1, 1, 0); sort_in(1, 0, 1, 0);
    sort_in(0, 0, 1, 1); idle(1);
    // Timeout: stall stuck until mem_error, then released and sticky.
    for (int i = 0; i < int'(MT) + 3; i++) step(0, 0, 2'b00, 4'h0, 0, 0, 1, 0);
    sort_in(0, 0, 1, 0); sort_in(0, 0, 1, 0); idle(2);
    // Reset mid-SORT2, then a fresh SORT restarts at the first half.
    step(1, 1, 2'b00, 4'b0011, 0, 0, 0, 1);
    step(0, 0, 2'b00, 4'h0, 0, 0, 0, 1);
    sort_in(0, 0, 0, 1); step(1, 1, 2'b00, 4'b0011, 0, 0, 0, 1);
    sort_in(0, 0, 0, 1); sort_in(0, 0, 0, 1); idle(1);
    // Randomized traffic with occasional resets and long SRAM stalls.
    for (int i = 0; i < 2000; i++) begin
      r  = (i % 500) == 499;
      v  = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 1) == 1) begin
        m = 2'b00; op = 4'b0011;
      end else begin
        m = 2'($urandom); op = 4'($urandom);
      end
      hz = $urandom_range(0, 4) == 0;
      br = $urandom_range(0, 9) == 0;
      ma = $urandom_range(0, 2) == 0;
      sr = ((i / 100) % 4 == 3) ? 1'b0 : 1'($urandom);
      step(r, v, m, op, hz, br, ma, sr);
    end
    idle(1);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
